// File: rtl/alu_pipe_core_if.sv
// alu_pipe_core_if: operand/result valid-ready channels of the pipelined ALU.
interface alu_pipe_core_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_res;
   logic [3:0]       out_flags;
   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_res, out_flags
   );
   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_res, out_flags
   );
endinterface

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: two-stage stall-all ALU pipeline with {Z,N,C,V} flags.
// Define ALU_SAT_EN to saturate signed add/sub results on overflow.
module alu_pipe_core #(
   parameter int WIDTH = 8
) (
   input logic            clk,
   input logic            rst,
   alu_pipe_core_if.slave bus
);
   logic             adv;
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [2:0]       s1_op_q, s1_op_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_res_q, out_res_d;
   logic [3:0]       out_flags_q, out_flags_d;
   logic             sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             ovf;
   logic [WIDTH-1:0] arith;
   logic [WIDTH-1:0] res;
   logic             c;
   logic             v;
   assign adv           = !out_valid_q || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.out_res   = out_res_q;
   assign bus.out_flags = out_flags_q;
   // Subtraction reuses the adder as A + ~B + 1; overflow test is shared.
   always_comb begin
      sub   = s1_op_q == 3'b001;
      b_eff = sub ? ~s1_b_q : s1_b_q;
      sum   = {1'b0, s1_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
      ovf   = (s1_a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
`ifdef ALU_SAT_EN
      arith = ovf ? {s1_a_q[WIDTH-1], {(WIDTH-1){!s1_a_q[WIDTH-1]}}} : sum[WIDTH-1:0];
`else
      arith = sum[WIDTH-1:0];
`endif
   end
   always_comb begin
      res = arith;
      c   = 1'b0;
      v   = 1'b0;
      case (s1_op_q)
         3'b000: begin
            c = sum[WIDTH];
            v = ovf;
         end
         3'b001: begin
            c = !sum[WIDTH];
            v = ovf;
         end
         3'b010: res = s1_a_q & s1_b_q;
         3'b011: res = s1_a_q | s1_b_q;
         3'b100: begin
            res = {s1_a_q[WIDTH-2:0], 1'b0};
            c   = s1_a_q[WIDTH-1];
         end
         3'b101: begin
            res = {1'b0, s1_a_q[WIDTH-1:1]};
            c   = s1_a_q[0];
         end
         3'b110: begin
            res = {s1_b_q[WIDTH-2:0], 1'b0};
            c   = s1_b_q[WIDTH-1];
         end
         default: begin
            res = {1'b0, s1_b_q[WIDTH-1:1]};
            c   = s1_b_q[0];
         end
      endcase
   end
   always_comb begin
      s1_valid_d  = adv ? bus.in_valid : s1_valid_q;
      s1_a_d      = adv ? bus.in_a : s1_a_q;
      s1_b_d      = adv ? bus.in_b : s1_b_q;
      s1_op_d     = adv ? bus.in_op : s1_op_q;
      out_valid_d = adv ? s1_valid_q : out_valid_q;
      out_res_d   = adv ? res : out_res_q;
      out_flags_d = adv ? {res == '0, res[WIDTH-1], c, v} : out_flags_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_op_q     <= '0;
         out_valid_q <= 1'b0;
         out_res_q   <= '0;
         out_flags_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_op_q     <= s1_op_d;
         out_valid_q <= out_valid_d;
         out_res_q   <= out_res_d;
         out_flags_q <= out_flags_d;
      end
   end
endmodule

// File: tb/tb_alu_pipe_core.sv
// tb_alu_pipe_core: directed and randomized scoreboard bench for alu_pipe_core.
module tb_alu_pipe_core;
   localparam int WIDTH = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_checks = 0;
   int n_fail = 0;
   int n_out = 0;
   logic acc = 1'b0;
   logic last_in_ready = 1'b0;
   logic prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_res;
   logic [3:0] prev_flags;
   logic [WIDTH+3:0] q[$];

   alu_pipe_core_if #(.WIDTH(WIDTH)) bus ();
   alu_pipe_core #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views of the operands.
   function automatic logic [WIDTH+3:0] model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [2:0] op);
      longint m, ua, ub, sa, sb, r, s;
      logic c, v;
      logic [WIDTH-1:0] rr;
      m  = longint'(1) << WIDTH;
      ua = longint'(a);
      ub = longint'(b);
      sa = ua >= m / 2 ? ua - m : ua;
      sb = ub >= m / 2 ? ub - m : ub;
      s  = 0;
      c  = 1'b0;
      v  = 1'b0;
      case (op)
         3'd0: begin r = (ua + ub) % m; c = (ua + ub) >= m; s = sa + sb; v = s > m / 2 - 1 || s < -(m / 2); end
         3'd1: begin r = (ua - ub + m) % m; c = ua < ub; s = sa - sb; v = s > m / 2 - 1 || s < -(m / 2); end
         3'd2: r = ua & ub;
         3'd3: r = ua | ub;
         3'd4: begin r = (ua * 2) % m; c = ua >= m / 2; end
         3'd5: begin r = ua / 2; c = ua % 2 == 1; end
         3'd6: begin r = (ub * 2) % m; c = ub >= m / 2; end
         default: begin r = ub / 2; c = ub % 2 == 1; end
      endcase
`ifdef ALU_SAT_EN
      if (op < 3'd2 && v) r = s > 0 ? m / 2 - 1 : m / 2;
`endif
      rr = r[WIDTH-1:0];
      return {rr, rr == 0, r >= m / 2, c, v};
   endfunction

   task automatic monitor();
      logic [WIDTH+3:0] e;
      acc = 1'b0;
      last_in_ready = bus.in_ready;
      if (rst) begin
         q.delete();
         prev_stall = 1'b0;
         return;
      end
      check("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (prev_stall) begin
         check("stall_valid", bus.out_valid, 1'b1);
         check("stall_res", bus.out_res, prev_res);
         check("stall_flags", bus.out_flags, prev_flags);
      end
      if (bus.out_valid && bus.out_ready) begin
         n_out++;
         check("beat_expected", q.size() > 0, 1'b1);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("out_res", bus.out_res, e[WIDTH+3:4]);
            check("out_flags", bus.out_flags, e[3:0]);
         end
      end
      if (bus.in_valid && bus.in_ready) begin
         q.push_back(model(bus.in_a, bus.in_b, bus.in_op));
         acc = 1'b1;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_res = bus.out_res;
      prev_flags = bus.out_flags;
   endtask

   task automatic tick();
      #1;
      monitor();
      @(negedge clk);
   endtask

   task automatic direct(string tag, logic [2:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                         logic [WIDTH-1:0] er, logic [3:0] ef);
      bus.in_valid = 1'b1;
      bus.in_op = op;
      bus.in_a = a;
      bus.in_b = b;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      #1;
      check({tag, "_lat1"}, bus.out_valid, 1'b0);
      tick();
      #1;
      check({tag, "_valid"}, bus.out_valid, 1'b1);
      check({tag, "_res"}, bus.out_res, er);
      check({tag, "_flags"}, bus.out_flags, ef);
      tick();
   endtask

   initial begin
      int idx, base, cyc, beats;
      logic [WIDTH-1:0] va[6], vb[6];
      logic [2:0] vo[6];
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.in_op = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_res", bus.out_res, 0);
      check("rst_out_flags", bus.out_flags, 0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      @(negedge clk);

`ifdef ALU_SAT_EN
      direct("add_ovf", 3'b000, 8'h7F, 8'h01, 8'h7F, 4'b0001);
      direct("sub_ovf", 3'b001, 8'h80, 8'h01, 8'h80, 4'b0101);
`else
      direct("add_ovf", 3'b000, 8'h7F, 8'h01, 8'h80, 4'b0101);
      direct("sub_ovf", 3'b001, 8'h80, 8'h01, 8'h7F, 4'b0001);
`endif
      direct("add_carry", 3'b000, 8'hFF, 8'h01, 8'h00, 4'b1010);
      direct("sub_zero", 3'b001, 8'h05, 8'h05, 8'h00, 4'b1000);
      direct("sub_borrow", 3'b001, 8'h03, 8'h05, 8'hFE, 4'b0110);
      direct("shl_a", 3'b100, 8'h81, 8'h00, 8'h02, 4'b0010);
      direct("shr_a", 3'b101, 8'h81, 8'h00, 8'h40, 4'b0010);
      direct("shl_b", 3'b110, 8'h00, 8'h40, 8'h80, 4'b0100);
      direct("shr_b", 3'b111, 8'h00, 8'h03, 8'h01, 4'b0010);
      direct("and", 3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000);
      direct("or", 3'b011, 8'hF0, 8'h3C, 8'hFC, 4'b0100);

      // Six back-to-back beats with the consumer stalled on cycles 3-5.
      for (int i = 0; i < 6; i++) begin
         va[i] = WIDTH'($urandom);
         vb[i] = WIDTH'($urandom);
         vo[i] = 3'(i);
      end
      idx = 0;
      base = n_out;
      for (int i = 0; i < 20 && (idx < 6 || q.size() > 0); i++) begin
         bus.out_ready = !(i >= 3 && i <= 5);
         bus.in_valid = idx < 6;
         if (idx < 6) begin
            bus.in_a = va[idx];
            bus.in_b = vb[idx];
            bus.in_op = vo[idx];
         end
         tick();
         if (i >= 3 && i <= 5) check("stall_in_ready_low", last_in_ready, 1'b0);
         if (acc) idx++;
      end
      check("stream_accepted", idx, 6);
      check("stream_emitted", n_out - base, 6);
      check("stream_drained", q.size(), 0);

      // Two beats in flight when reset hits; neither may ever emerge.
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_op = 3'b000;
      bus.in_a = 8'h11;
      bus.in_b = 8'h22;
      tick();
      bus.in_a = 8'h33;
      tick();
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check("rst_flush_valid", bus.out_valid, 1'b0);
      base = n_out;
      for (int i = 0; i < 6; i++) tick();
      check("rst_flush_none", n_out - base, 0);

      // Randomized traffic against the scoreboard.
      beats = 0;
      cyc = 0;
      bus.in_valid = 1'b0;
      while (beats < 10000 && cyc < 60000) begin
         if (acc || !bus.in_valid) begin
            bus.in_valid = $urandom_range(0, 3) != 0;
            bus.in_a = WIDTH'($urandom);
            bus.in_b = WIDTH'($urandom);
            bus.in_op = 3'($urandom);
         end
         bus.out_ready = $urandom_range(0, 3) != 0;
         tick();
         if (acc) beats++;
         cyc++;
      end
      check("rand_beats", beats, 10000);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() > 0; i++) tick();
      check("rand_drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
